// File: rtl/echo_mixer_if.sv
// Stereo echo mixer bus: dry sample in, SRAM delay-line handshake, mixed sample out.
interface echo_mixer_if;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        bypass;
  logic        clr_overrun;
  logic [31:0] sram_data;
  logic        rw_trigger;
  logic [31:0] write_data;
  logic        ready;
  logic [31:0] mix_out;
  logic        mix_valid;
  logic        overrun;

  modport master (
    output sample_in, sample_valid, bypass, clr_overrun, sram_data,
    input  rw_trigger, write_data, ready, mix_out, mix_valid, overrun
  );

  modport slave (
    input  sample_in, sample_valid, bypass, clr_overrun, sram_data,
    output rw_trigger, write_data, ready, mix_out, mix_valid, overrun
  );
endinterface

// File: rtl/echo_mixer.sv
// Echo mixer: one SRAM read-then-write per accepted sample, mixing the dry sample
// with the attenuated delayed sample per 16-bit lane with saturation.
module echo_mixer #(
  parameter int SRAM_LAT  = 6,
  parameter int CYCLE_LEN = 10,
  parameter int WET_SHIFT = 1
) (
  input logic         clk,
  input logic         n_rst,
  echo_mixer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TRIG = 3'd1,
    WAIT = 3'd2,
    MIX  = 3'd3,
    OUT  = 3'd4,
    HOLD = 3'd5
  } state_t;

  localparam logic [3:0] LAT_CNT  = 4'(SRAM_LAT);
  // cnt is compared before its increment, so HOLD exits one count early to land IDLE on time
  localparam logic [3:0] HOLD_END = 4'(CYCLE_LEN - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [31:0] write_data_r;
  logic [31:0] dry_r;
  logic [31:0] wet_r;
  logic [31:0] mix_out_r;
  logic        rw_trigger_r;
  logic        mix_valid_r;
  logic        ready_r;
  logic        overrun_r;
  logic        accept_s;
  logic        drop_s;

  function automatic logic [15:0] mix_lane(input logic [15:0] dry, input logic [15:0] wet);
    logic signed [16:0] dry_x;
    logic signed [16:0] wet_x;
    logic signed [16:0] sum;
    dry_x = signed'({dry[15], dry});
    wet_x = signed'({wet[15], wet}) >>> WET_SHIFT;
    sum   = dry_x + wet_x;
    if (sum > 17'sd32767) begin
      return 16'h7FFF;
    end else if (sum < -17'sd32768) begin
      return 16'h8000;
    end else begin
      return sum[15:0];
    end
  endfunction

  assign accept_s = bus.sample_valid && (state_r == IDLE);
  assign drop_s   = bus.sample_valid && !ready_r;

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.sample_valid) state_s = TRIG;
        else                  state_s = IDLE;
      end
      TRIG: state_s = WAIT;
      WAIT: begin
        if (cnt_r == LAT_CNT) state_s = MIX;
        else                  state_s = WAIT;
      end
      MIX:  state_s = OUT;
      OUT:  state_s = HOLD;
      HOLD: begin
        if (cnt_r == HOLD_END) state_s = IDLE;
        else                   state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counter, datapath and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      write_data_r <= 32'd0;
      dry_r        <= 32'd0;
      wet_r        <= 32'd0;
      mix_out_r    <= 32'd0;
      rw_trigger_r <= 1'b0;
      mix_valid_r  <= 1'b0;
      ready_r      <= 1'b1;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      rw_trigger_r <= accept_s;
      mix_valid_r  <= (state_r == MIX);
      ready_r      <= (state_s == IDLE);
      overrun_r    <= drop_s || (overrun_r && !bus.clr_overrun);

      case (state_r)
        IDLE:    cnt_r <= 4'd0;
        TRIG:    cnt_r <= 4'd1;
        default: cnt_r <= cnt_r + 4'd1;
      endcase

      if (accept_s) begin
        write_data_r <= bus.sample_in;
        dry_r        <= bus.sample_in;
      end

      if ((state_r == WAIT) && (cnt_r == LAT_CNT)) begin
        wet_r <= bus.sram_data;
      end

      if (state_r == MIX) begin
        if (bus.bypass) mix_out_r <= dry_r;
        else            mix_out_r <= {mix_lane(dry_r[31:16], wet_r[31:16]),
                                      mix_lane(dry_r[15:0],  wet_r[15:0])};
      end
    end
  end

  assign bus.rw_trigger = rw_trigger_r;
  assign bus.write_data = write_data_r;
  assign bus.ready      = ready_r;
  assign bus.mix_out    = mix_out_r;
  assign bus.mix_valid  = mix_valid_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_echo_mixer.sv
// Self-checking bench for echo_mixer: latency-based transaction model plus directed cases.
module tb_echo_mixer;
  localparam int SRAM_LAT  = 6;
  localparam int CYCLE_LEN = 10;
  localparam int WET_SHIFT = 1;

  logic clk;
  logic n_rst;
  echo_mixer_if bus ();

  echo_mixer #(.SRAM_LAT(SRAM_LAT), .CYCLE_LEN(CYCLE_LEN), .WET_SHIFT(WET_SHIFT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: everything is expressed relative to the cycle of the last accepted sample.
  int          t;
  int          acc_t;
  logic [31:0] m_wd;
  logic [31:0] m_dry;
  logic [31:0] m_wet;
  logic [31:0] m_mix;
  logic        m_over;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_mix(input logic [15:0] d, input logic [15:0] w);
    int dv;
    int wv;
    int s;
    dv = $signed(d);
    wv = $signed(w);
    s  = dv + (wv >>> WET_SHIFT);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic model_reset();
    acc_t  = -1000;
    m_wd   = 32'd0;
    m_dry  = 32'd0;
    m_wet  = 32'd0;
    m_mix  = 32'd0;
    m_over = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rw"},    {31'd0, bus.rw_trigger}, 32'd0);
    check_eq({tag, "_mv"},    {31'd0, bus.mix_valid},  32'd0);
    check_eq({tag, "_ovr"},   {31'd0, bus.overrun},    32'd0);
    check_eq({tag, "_wd"},    bus.write_data,          32'd0);
    check_eq({tag, "_mix"},   bus.mix_out,             32'd0);
    check_eq({tag, "_ready"}, {31'd0, bus.ready},      32'd1);
  endtask

  // One cycle: check outputs against the model, then drive this cycle's inputs.
  task automatic step(input logic v, input logic [31:0] s, input logic [31:0] sd,
                      input logic byp, input logic clr);
    int   rel;
    logic exp_ready;
    @(negedge clk);
    t++;
    rel       = t - acc_t;
    exp_ready = !(rel >= 1 && rel <= CYCLE_LEN);
    check_eq("ready",      {31'd0, bus.ready},      {31'd0, exp_ready});
    check_eq("rw_trigger", {31'd0, bus.rw_trigger}, {31'd0, rel == 1});
    check_eq("mix_valid",  {31'd0, bus.mix_valid},  {31'd0, rel == SRAM_LAT + 3});
    check_eq("mix_out",    bus.mix_out,             m_mix);
    check_eq("write_data", bus.write_data,          m_wd);
    check_eq("overrun",    {31'd0, bus.overrun},    {31'd0, m_over});
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.sram_data    = sd;
    bus.bypass       = byp;
    bus.clr_overrun  = clr;
    if (rel == SRAM_LAT + 1) m_wet = sd;
    if (rel == SRAM_LAT + 2)
      m_mix = byp ? m_dry : {sat_mix(m_dry[31:16], m_wet[31:16]), sat_mix(m_dry[15:0], m_wet[15:0])};
    if (v && exp_ready) begin
      acc_t = t;
      m_wd  = s;
      m_dry = s;
    end
    m_over = (v && !exp_ready) || (m_over && !clr);
  endtask

  task automatic run_seq(input logic [31:0] dry, input logic [31:0] wet, input logic byp);
    step(1'b1, dry, wet, byp, 1'b0);
    for (int i = 0; i < CYCLE_LEN + 1; i++) step(1'b0, 32'd0, wet, byp, 1'b0);
  endtask

  initial begin
    t = 0;
    model_reset();
    n_rst            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = 32'd0;
    bus.sram_data    = 32'd0;
    bus.bypass       = 1'b0;
    bus.clr_overrun  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    n_rst = 1'b1;

    // Basic mix, saturation, bypass with fixed literal expectations too
    run_seq(32'h1000_0100, 32'h2000_0200, 1'b0);
    check_eq("basic_lit", bus.mix_out, 32'h2000_0200);
    run_seq(32'h7000_9000, 32'h7000_9000, 1'b0);
    check_eq("sat_lit", bus.mix_out, 32'h7FFF_8000);
    run_seq(32'h1234_5678, 32'h7FFF_7FFF, 1'b1);
    check_eq("bypass_lit", bus.mix_out, 32'h1234_5678);
    check_eq("bypass_wd", bus.write_data, 32'h1234_5678);

    // Overrun: second sample three cycles after the first is dropped
    step(1'b1, 32'hAAAA_5555, 32'h0101_0202, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'h0101_0202, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'h0101_0202, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'h0101_0202, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 32'd0, 32'h0101_0202, 1'b0, 1'b0);
    check_eq("ovr_wd_lit", bus.write_data, 32'hAAAA_5555);
    check_eq("ovr_flag_lit", {31'd0, bus.overrun}, 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset in WAIT, then a fresh sample at nominal latency
    step(1'b1, 32'h0800_F000, 32'h1000_1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'h1000_1000, 1'b0, 1'b0);
    @(negedge clk);
    t++;
    n_rst            = 1'b0;
    bus.sample_valid = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    t++;
    n_rst = 1'b1;
    run_seq(32'h0001_FFFF, 32'h0004_FFFC, 1'b0);

    // Back-to-back: valid held high, each IDLE cycle accepts
    for (int i = 0; i < 3 * (CYCLE_LEN + 1); i++)
      step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 2) == 0, $urandom, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
